// File: rtl/hilo_result_unit.sv
// hilo_result_unit: owns the architectural HI/LO registers, tracks the single
// outstanding mult/div operation, selects which result source writes HI/LO,
// stalls mfhi/mflo while a result is pending, and guards the wait with a
// watchdog. Illegal accesses and watchdog expiry are reported as registered pulses.
module hilo_result_unit #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 2,
    parameter int SRC_W   = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SRC_W-1:0]      start_src,
    input  logic [NSRC*WIDTH-1:0] src_hi,
    input  logic [NSRC*WIDTH-1:0] src_lo,
    input  logic [NSRC-1:0]       src_done,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_req,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo,
    output logic                  busy,
    output logic                  stall,
    output logic                  illegal,
    output logic                  timeout
);

    // Every encodable source index gets a slot; slots beyond NSRC read as
    // invalid/zero so indexing by a full SRC_W-bit value is always in range.
    localparam int SRC_CNT = 2 ** SRC_W;
    // cnt only needs to reach TIMEOUT-1; with the watchdog off it just wraps.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [SRC_W-1:0]  pend_src_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  hi_reg;
    logic [WIDTH-1:0]  lo_reg;
    logic              illegal_reg;
    logic              timeout_reg;

    logic [WIDTH-1:0]  hi_arr [SRC_CNT];
    logic [WIDTH-1:0]  lo_arr [SRC_CNT];
    logic [SRC_CNT-1:0] done_arr;
    logic [SRC_CNT-1:0] src_valid;

    logic start_ok;
    logic capture;
    logic wd_fire;

    // Unpack the per-source result buses; unused index slots are tied off.
    generate
        for (genvar gi = 0; gi < SRC_CNT; gi++) begin : g_src
            if (gi < NSRC) begin : g_used
                assign hi_arr[gi]    = src_hi[gi*WIDTH +: WIDTH];
                assign lo_arr[gi]    = src_lo[gi*WIDTH +: WIDTH];
                assign done_arr[gi]  = src_done[gi];
                assign src_valid[gi] = 1'b1;
            end else begin : g_unused
                assign hi_arr[gi]    = '0;
                assign lo_arr[gi]    = '0;
                assign done_arr[gi]  = 1'b0;
                assign src_valid[gi] = 1'b0;
            end
        end
    endgenerate

    assign start_ok = start & src_valid[start_src];
    // Only the done of the source we are waiting on completes the operation.
    assign capture  = (state_reg == ST_WAIT) & done_arr[pend_src_reg];
    // A done in the same cycle beats the watchdog.
    assign wd_fire  = WD_EN & (state_reg == ST_WAIT) & ~capture & (cnt_reg == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: launch on a legal start, return on capture or watchdog.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_ok) state_next = ST_WAIT;
            ST_WAIT: if (capture || wd_fire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: busy follows the state; stall is the combinational read hazard.
    always_comb begin
        busy  = (state_reg == ST_WAIT);
        stall = rd_req & (state_reg == ST_WAIT);
    end

    // HI/LO, pending source, watchdog counter and event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            pend_src_reg <= '0;
            cnt_reg      <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE) begin
                if (mthi) hi_reg <= wr_data;
                if (mtlo) lo_reg <= wr_data;
                if (start_ok) begin
                    pend_src_reg <= start_src;
                    cnt_reg      <= '0;
                end
            end else begin
                if (capture) begin
                    hi_reg <= hi_arr[pend_src_reg];
                    lo_reg <= lo_arr[pend_src_reg];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            // In WAIT any start or move-to is refused; in IDLE only an
            // out-of-range start is.
            illegal_reg <= (state_reg == ST_IDLE) ? (start & ~start_ok)
                                                  : (start | mthi | mtlo);
            timeout_reg <= wd_fire;
        end
    end

    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign illegal = illegal_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_hilo_result_unit.sv
// Directed testbench for hilo_result_unit (NSRC=2, SRC_W=2, TIMEOUT=4).
module tb_hilo_result_unit;

    localparam int WIDTH   = 32;
    localparam int NSRC    = 2;
    localparam int SRC_W   = 2;
    localparam int TIMEOUT = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [SRC_W-1:0]      start_src;
    logic [NSRC*WIDTH-1:0] src_hi;
    logic [NSRC*WIDTH-1:0] src_lo;
    logic [NSRC-1:0]       src_done;
    logic                  mthi;
    logic                  mtlo;
    logic [WIDTH-1:0]      wr_data;
    logic                  rd_req;
    logic [WIDTH-1:0]      hi;
    logic [WIDTH-1:0]      lo;
    logic                  busy;
    logic                  stall;
    logic                  illegal;
    logic                  timeout;

    int checks   = 0;
    int failures = 0;

    hilo_result_unit #(
        .WIDTH  (WIDTH),
        .NSRC   (NSRC),
        .SRC_W  (SRC_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .start_src(start_src),
        .src_hi   (src_hi),
        .src_lo   (src_lo),
        .src_done (src_done),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .illegal  (illegal),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_src = '0; src_hi = '0; src_lo = '0;
        src_done = '0; mthi = 1'b0; mtlo = 1'b0; wr_data = '0; rd_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_illegal", {31'b0, illegal}, 32'h0);
        check("rst_timeout", {31'b0, timeout}, 32'h0);

        // 1: multiplier op, done arrives in the 4th WAIT cycle (beats watchdog)
        start = 1'b1; start_src = 2'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_busy_c%0d", i + 1), {31'b0, busy}, 32'h1);
            if (i < 3) tick();
        end
        src_done = 2'b10;
        src_hi = {32'h0000_0001, 32'h0};
        src_lo = {32'hFFFF_FFFE, 32'h0};
        tick();
        src_done = '0;
        check("t1_hi", hi, 32'h0000_0001);
        check("t1_lo", lo, 32'hFFFF_FFFE);
        check("t1_busy_after", {31'b0, busy}, 32'h0);
        check("t1_timeout", {31'b0, timeout}, 32'h0);

        // 2: divider op, stray multiplier done ignored
        start = 1'b1; start_src = 2'd0;
        tick();
        start = 1'b0;
        check("t2_illegal_start", {31'b0, illegal}, 32'h0);
        src_done = 2'b10;
        src_hi = {32'hBAD0_BAD0, 32'h1111_1111};
        src_lo = {32'hBAD1_BAD1, 32'h2222_2222};
        tick();
        check("t2_busy_after_stray", {31'b0, busy}, 32'h1);
        check("t2_hi_after_stray", hi, 32'h0000_0001);
        check("t2_illegal_stray", {31'b0, illegal}, 32'h0);
        src_done = 2'b01;
        src_hi = {32'hBAD0_BAD0, 32'h0000_0007};
        src_lo = {32'hBAD1_BAD1, 32'h0000_0003};
        tick();
        src_done = '0;
        check("t2_hi", hi, 32'h0000_0007);
        check("t2_lo", lo, 32'h0000_0003);
        check("t2_busy", {31'b0, busy}, 32'h0);
        check("t2_illegal", {31'b0, illegal}, 32'h0);

        // 3: stall, illegal mthi and illegal start while waiting
        start = 1'b1; start_src = 2'd1;
        tick();
        start = 1'b0;
        rd_req = 1'b1; mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
        #1;
        check("t3_stall_a", {31'b0, stall}, 32'h1);
        tick();
        check("t3_illegal_mthi", {31'b0, illegal}, 32'h1);
        check("t3_hi_kept", hi, 32'h0000_0007);
        mthi = 1'b0; start = 1'b1; start_src = 2'd0;
        #1;
        check("t3_stall_b", {31'b0, stall}, 32'h1);
        tick();
        check("t3_illegal_start", {31'b0, illegal}, 32'h1);
        start = 1'b0; rd_req = 1'b0;
        #1;
        check("t3_stall_off", {31'b0, stall}, 32'h0);
        src_done = 2'b10;
        src_hi = {32'hA5A5_A5A5, 32'h0};
        src_lo = {32'h5A5A_5A5A, 32'h0};
        tick();
        src_done = '0;
        check("t3_illegal_clear", {31'b0, illegal}, 32'h0);
        check("t3_hi", hi, 32'hA5A5_A5A5);
        check("t3_lo", lo, 32'h5A5A_5A5A);
        check("t3_busy", {31'b0, busy}, 32'h0);

        // 4: mthi+mtlo together in IDLE, then out-of-range start
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h1234_5678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("t4_hi", hi, 32'h1234_5678);
        check("t4_lo", lo, 32'h1234_5678);
        start = 1'b1; start_src = 2'd3;
        tick();
        start = 1'b0;
        check("t4_illegal", {31'b0, illegal}, 32'h1);
        check("t4_busy", {31'b0, busy}, 32'h0);
        tick();
        check("t4_illegal_pulse", {31'b0, illegal}, 32'h0);
        check("t4_busy_idle", {31'b0, busy}, 32'h0);

        // 5a: no done -> watchdog fires after the 4th WAIT cycle
        start = 1'b1; start_src = 2'd0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t5a_busy_c4", {31'b0, busy}, 32'h1);
        check("t5a_timeout_c4", {31'b0, timeout}, 32'h0);
        tick();
        check("t5a_timeout", {31'b0, timeout}, 32'h1);
        check("t5a_busy", {31'b0, busy}, 32'h0);
        check("t5a_hi", hi, 32'h1234_5678);
        check("t5a_lo", lo, 32'h1234_5678);
        tick();
        check("t5a_timeout_pulse", {31'b0, timeout}, 32'h0);

        // 5b: done in the 4th WAIT cycle wins over the watchdog
        start = 1'b1; start_src = 2'd0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        src_done = 2'b01;
        src_hi = {32'h0, 32'hCAFE_0000};
        src_lo = {32'h0, 32'h0000_BEEF};
        tick();
        src_done = '0;
        check("t5b_hi", hi, 32'hCAFE_0000);
        check("t5b_lo", lo, 32'h0000_BEEF);
        check("t5b_timeout", {31'b0, timeout}, 32'h0);
        check("t5b_busy", {31'b0, busy}, 32'h0);
        tick();
        check("t5b_timeout_next", {31'b0, timeout}, 32'h0);

        // 6: reset mid-operation discards it
        start = 1'b1; start_src = 2'd1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_hi_rst", hi, 32'h0);
        check("t6_lo_rst", lo, 32'h0);
        check("t6_busy_rst", {31'b0, busy}, 32'h0);
        src_done = 2'b10;
        src_hi = {32'h7777_7777, 32'h0};
        src_lo = {32'h8888_8888, 32'h0};
        tick();
        src_done = '0;
        check("t6_hi", hi, 32'h0);
        check("t6_lo", lo, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'h0);
        check("t6_illegal", {31'b0, illegal}, 32'h0);
        check("t6_timeout", {31'b0, timeout}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
